// File: rtl/word_unpacker.sv
// 32-bit word to LSB-first byte serializer behind a FIFO_DEPTH-entry input FIFO.
// Latency: first byte one cycle after the word is written; input backpressured by registered in_ready, output never stalls.
module word_unpacker #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          overflow_q, overflow_d;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;

  logic push;
  logic pop;
  logic fifo_empty;

  assign push       = in_valid && in_ready_q;
  assign fifo_empty = (cnt_q == '0);
  // Pop whenever the serializer can take a word: from IDLE, or on the last byte.
  assign pop        = !fifo_empty && ((state_q == IDLE) || (idx_q == 2'd3));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // in_ready reflects post-edge occupancy, so it is stable for the whole next cycle.
  assign in_ready_d = (cnt_d < DEPTH_C);
  assign overflow_d = overflow_q | (in_valid & ~in_ready_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SEND;
          idx_d   = 2'd0;
          word_d  = mem_q[rd_ptr_q];
        end
      end
      SEND: begin
        if (idx_q == 2'd3) begin
          idx_d = 2'd0;
          if (!fifo_empty) begin
            word_d = mem_q[rd_ptr_q];
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      word_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign overflow  = overflow_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? word_q[{idx_q, 3'b000} +: 8] : 8'd0;
  assign out_last  = out_valid && (idx_q == 2'd3);

endmodule

// File: tb/tb_word_unpacker.sv
// Directed bench for word_unpacker: latency, back-to-back, overflow, reset abort and pointer wrap.
module tb_word_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_dat [$];
  logic       exp_lst [$];

  logic [31:0] ow [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                          32'h44444444, 32'h55555555, 32'h66666666};

  always #5 clk = ~clk;

  word_unpacker #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      exp_dat.push_back(w[8*b +: 8]);
      exp_lst.push_back(b == 3);
    end
  endtask

  task automatic drain(input string tag);
    int budget = 200;
    while (exp_dat.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, exp_dat.size(), 32'd0);
    @(negedge clk);
  endtask

  // Byte scoreboard plus idle-output check on every falling edge.
  always @(negedge clk) begin : mon
    logic [7:0] ed;
    logic       el;
    if (out_valid) begin
      if (exp_dat.size() == 0) begin
        check("extra_byte", {31'd0, out_valid}, 32'd0);
      end else begin
        ed = exp_dat.pop_front();
        el = exp_lst.pop_front();
        check("byte_dat", {24'd0, out_data}, {24'd0, ed});
        check("byte_lst", {31'd0, out_last}, {31'd0, el});
      end
    end else begin
      check("idle_dat", {24'd0, out_data}, 32'd0);
      check("idle_lst", {31'd0, out_last}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sent;
    int budget;
    logic [7:0] b0;
    logic [5:0] rdy_exp;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", {31'd0, in_ready}, 32'd1);

    // Single word with exact latency.
    expect_word(32'h44332211);
    in_valid = 1'b1;
    in_data  = 32'h44332211;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_written", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lat_vld%0d", i), {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    check("lat_end", {31'd0, out_valid}, 32'd0);

    // Back-to-back words, no gap.
    expect_word(32'hDDCCBBAA);
    expect_word(32'h04030201);
    in_valid = 1'b1;
    in_data  = 32'hDDCCBBAA;
    @(negedge clk);
    in_data  = 32'h04030201;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_vld%0d", i), {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    check("b2b_end", {31'd0, out_valid}, 32'd0);

    // Fill to full; sixth word dropped.
    check("ovf_pre", {31'd0, overflow}, 32'd0);
    rdy_exp = 6'b011111;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("ovf_rdy%0d", k), {31'd0, in_ready}, {31'd0, rdy_exp[k]});
      in_valid = 1'b1;
      in_data  = ow[k];
      if (k < 5) expect_word(ow[k]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ovf_set", {31'd0, overflow}, 32'd1);
    drain("ovf_drain");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset after byte 1 aborts the word.
    exp_dat.push_back(8'hD4); exp_lst.push_back(1'b0);
    exp_dat.push_back(8'hC3); exp_lst.push_back(1'b0);
    in_valid = 1'b1;
    in_data  = 32'hA1B2C3D4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    check("mid_rst_dat", {24'd0, out_data}, 32'd0);
    check("mid_rst_lst", {31'd0, out_last}, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_vld%0d", i), {31'd0, out_valid}, 32'd0);
    end
    check("rst_abort_bytes", exp_dat.size(), 32'd0);
    check("post_rst_rdy", {31'd0, in_ready}, 32'd1);

    // Stream 64 words gated by in_ready.
    sent   = 0;
    budget = 2000;
    while (sent < 64 && budget > 0) begin
      if (in_ready) begin
        b0       = 8'(4 * sent);
        in_valid = 1'b1;
        in_data  = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
        expect_word({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      budget--;
    end
    in_valid = 1'b0;
    check("wrap_sent", sent, 32'd64);
    drain("wrap_drain");
    check("wrap_ovf", {31'd0, overflow}, 32'd0);
    check("wrap_idle", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
